// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM dimmer with key-driven UP/DOWN level adjust and a BREATH mode
// that ramps all levels together between LVL_MIN and LVL_MAX.
module rgb_pwm_ctrl #(
  parameter int unsigned CH       = 3,
  parameter int unsigned LVL_W    = 8,
  parameter int unsigned LVL_MIN  = 1,
  parameter int unsigned LVL_MAX  = 25,
  parameter int unsigned STEP_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         key_ch_i,
  input  logic                  key_mode_i,
  output logic [CH-1:0]         pwm_out_o,
  output logic [CH*LVL_W-1:0]   level_bus_o,
  output logic [1:0]            mode_o
);

  typedef enum logic [1:0] {
    ModeUp     = 2'd0,
    ModeDown   = 2'd1,
    ModeBreath = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  localparam int unsigned StepW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYC - 1);
  localparam logic [LVL_W-1:0] LvlMin   = LVL_W'(LVL_MIN);
  localparam logic [LVL_W-1:0] LvlMax   = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] PwmLast  = LVL_W'(LVL_MAX - 1);

  mode_e            mode_q, mode_d;
  logic [LVL_W-1:0] level_q  [CH];
  logic [LVL_W-1:0] level_d  [CH];
  logic [LVL_W-1:0] shadow_q [CH];
  logic [LVL_W-1:0] shadow_d [CH];
  logic [LVL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             dir_up_q, dir_up_d;
  logic [StepW-1:0] step_q, step_d;
  logic             step_tc, wrap, any_at_max, any_at_min, step_up, key_ok;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      ModeUp:     if (key_mode_i) mode_d = ModeDown;
      ModeDown:   if (key_mode_i) mode_d = ModeBreath;
      ModeBreath: if (key_mode_i) mode_d = ModeUp;
      default:    mode_d = ModeUp;
    endcase
  end

  always_comb begin
    any_at_max = 1'b0;
    any_at_min = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (level_q[i] >= LvlMax) any_at_max = 1'b1;
      if (level_q[i] <= LvlMin) any_at_min = 1'b1;
    end
  end

  // A blocked step in the current direction is replaced by a step the other way.
  assign step_up = dir_up_q ? !any_at_max : any_at_min;
  assign step_tc = (step_q == StepLast);
  assign key_ok  = !key_mode_i && $onehot(key_ch_i);

  always_comb begin
    step_d   = step_q;
    dir_up_d = dir_up_q;
    if (mode_q == ModeBreath) begin
      step_d = step_tc ? '0 : step_q + StepW'(1);
      if (step_tc) dir_up_d = step_up;
    end
    if (mode_d == ModeBreath && mode_q != ModeBreath) begin
      step_d   = '0;
      dir_up_d = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      level_d[i] = level_q[i];
      if (mode_q == ModeBreath) begin
        if (step_tc) begin
          if (step_up) level_d[i] = (level_q[i] >= LvlMax) ? LvlMax : level_q[i] + LVL_W'(1);
          else         level_d[i] = (level_q[i] <= LvlMin) ? LvlMin : level_q[i] - LVL_W'(1);
        end
      end else if (key_ok && key_ch_i[i]) begin
        if (mode_q == ModeUp)
          level_d[i] = (level_q[i] >= LvlMax) ? LvlMax : level_q[i] + LVL_W'(1);
        else if (mode_q == ModeDown)
          level_d[i] = (level_q[i] <= LvlMin) ? LvlMin : level_q[i] - LVL_W'(1);
      end
    end
  end

  assign wrap      = (pwm_cnt_q == PwmLast);
  assign pwm_cnt_d = wrap ? '0 : pwm_cnt_q + LVL_W'(1);

  // Shadows only change at the period boundary so a level edit never splits a period.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      shadow_d[i] = wrap ? level_q[i] : shadow_q[i];
      pwm_d[i]    = (pwm_cnt_q < shadow_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= ModeUp;
      dir_up_q  <= 1'b1;
      step_q    <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
      for (int i = 0; i < CH; i++) begin
        level_q[i]  <= LvlMin;
        shadow_q[i] <= LvlMin;
      end
    end else begin
      mode_q    <= mode_d;
      dir_up_q  <= dir_up_d;
      step_q    <= step_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      for (int i = 0; i < CH; i++) begin
        level_q[i]  <= level_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) level_bus_o[i*LVL_W +: LVL_W] = level_q[i];
  end

  assign pwm_out_o = pwm_q;
  assign mode_o    = mode_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl at CH=3, LVL_MIN=1, LVL_MAX=25, STEP_CYC=4.
module tb_rgb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  key_ch = '0;
  logic        key_mode = 1'b0;
  logic [2:0]  pwm;
  logic [23:0] level_bus;
  logic [1:0]  mode;

  int total = 0;
  int bad   = 0;

  rgb_pwm_ctrl #(
    .CH(3), .LVL_W(8), .LVL_MIN(1), .LVL_MAX(25), .STEP_CYC(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_ch_i   (key_ch),
    .key_mode_i (key_mode),
    .pwm_out_o  (pwm),
    .level_bus_o(level_bus),
    .mode_o     (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not finish, got hang want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_ch(input logic [2:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      key_ch = v;
      tick();
    end
    key_ch = '0;
  endtask

  task automatic pulse_mode();
    key_mode = 1'b1;
    tick();
    key_mode = 1'b0;
  endtask

  // Keys during reset, then release; first period starts at pwm_cnt 0 with levels 1.
  task automatic reset_release(input string tag);
    key_ch   = 3'b001;
    key_mode = 1'b1;
    tick();
    check({tag, "_lvl_in_rst"}, level_bus, 24'h010101);
    check({tag, "_mode_in_rst"}, mode, 0);
    check({tag, "_pwm_in_rst"}, pwm, 0);
    key_ch   = '0;
    key_mode = 1'b0;
    rst_n    = 1'b1;
    tick();
    check({tag, "_pwm_first"}, pwm, 3'b111);
    check({tag, "_lvl_after"}, level_bus, 24'h010101);
    check({tag, "_mode_after"}, mode, 0);
    tick();
    check({tag, "_pwm_second"}, pwm, 3'b000);
  endtask

  int hi0, hi1, hi2, n;
  logic [2:0] s2 [50];
  logic [7:0] e;

  initial begin
    tick();
    tick();
    reset_release("rst0");

    pulse_ch(3'b001, 1);
    check("up_one", level_bus, 24'h010102);
    pulse_ch(3'b001, 29);
    check("up_sat", level_bus, 24'h010119);

    repeat (26) tick();
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
    end
    check("pwm0_full", hi0, 25);
    check("pwm1_one", hi1, 1);

    n = 0;
    while (n < 30 && pwm[1] !== 1'b1) begin
      tick();
      n++;
    end
    check("sync_pwm1", pwm[1], 1);
    check("s0_pwm2", pwm[2], 1);
    for (int s = 1; s < 50; s++) begin
      key_ch = (s <= 12) ? 3'b100 : 3'b000;
      tick();
      s2[s] = pwm;
    end
    key_ch = '0;
    check("lvl2_13", level_bus[23:16], 13);
    hi1 = 0;
    hi2 = 0;
    for (int s = 1; s < 25; s++) hi1 += int'(s2[s][2]);
    for (int s = 25; s < 50; s++) hi2 += int'(s2[s][2]);
    check("old_period_low", hi1, 0);
    check("new_period_hi", hi2, 13);
    check("new_period_c12", s2[37][2], 1);
    check("new_period_c13", s2[38][2], 0);
    check("wrap_pwm1", s2[25][1], 1);

    pulse_mode();
    check("mode_down", mode, 1);
    pulse_ch(3'b010, 30);
    check("down_sat", level_bus[15:8], 1);
    pulse_ch(3'b001, 1);
    check("down_one", level_bus, 24'h0D0118);
    pulse_ch(3'b011, 1);
    check("multi_bit", level_bus, 24'h0D0118);
    pulse_ch(3'b001, 30);
    pulse_ch(3'b100, 15);
    check("all_min", level_bus, 24'h010101);

    pulse_mode();
    check("mode_breath", mode, 2);
    for (int k = 1; k <= 256; k++) begin
      key_ch = (k >= 10 && k <= 12) ? 3'b001 : 3'b000;
      tick();
      n = (k / 4) % 48;
      e = (n <= 24) ? 8'(1 + n) : 8'(49 - n);
      check($sformatf("breath_k%0d", k), level_bus, {e, e, e});
    end
    key_ch = '0;
    check("breath_mode_held", mode, 2);

    rst_n = 1'b0;
    #1;
    check("async_lvl", level_bus, 24'h010101);
    check("async_mode", mode, 0);
    check("async_pwm", pwm, 0);
    reset_release("rst1");

    pulse_ch(3'b001, 3);
    check("up_three", level_bus, 24'h010104);
    key_mode = 1'b1;
    key_ch   = 3'b001;
    tick();
    key_mode = 1'b0;
    key_ch   = '0;
    check("simul_mode", mode, 1);
    check("simul_lvl", level_bus, 24'h010104);
    pulse_mode();
    check("to_breath", mode, 2);
    pulse_mode();
    check("to_up", mode, 0);
    check("retain_lvl", level_bus, 24'h010104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 Parameter CH, default 3, number of PWM channels (1..8).
REQ-002 Parameter LVL_W, default 8, level register width.
REQ-003 Parameter LVL_MIN, default 1, lowest allowed level.
REQ-004 Parameter LVL_MAX, default 25, highest allowed level and PWM period in clk cycles; LVL_MIN < LVL_MAX < 2**LVL_W.
REQ-005 Parameter STEP_CYC, default 1000000, clk cycles per level step in breathing mode (>=1).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 key_ch  input  CH  debounced one-cycle pulses, bit i = adjust channel i.
REQ-009 key_mode  input  1  debounced one-cycle pulse, advance mode.
REQ-010 pwm_out  output  CH  registered PWM drive, bit i = channel i, active-high.
REQ-011 level_bus  output  CH*LVL_W  current levels, channel i at bits [i*LVL_W +: LVL_W].
REQ-012 mode  output  2  current mode: 0 = UP, 1 = DOWN, 2 = BREATH.

Function
REQ-013 Mode FSM SHALL advance UP->DOWN->BREATH->UP on each key_mode pulse; encoding 3 unreachable, SHALL recover to UP on the next clock.
REQ-014 In UP, a key_ch pulse with exactly one bit i set SHALL increment level[i] by 1, saturating at LVL_MAX.
REQ-015 In DOWN, the same pulse SHALL decrement level[i] by 1, saturating at LVL_MIN.
REQ-016 key_ch with zero or more than one bit set SHALL change no level.
REQ-017 key_mode and key_ch in the same cycle: mode advances, key_ch ignored.
REQ-018 The level update SHALL be visible on level_bus the cycle after the pulse.
REQ-019 In BREATH, key_ch SHALL be ignored; a step counter counts 0..STEP_CYC-1; on terminal count every level SHALL step by 1 in the shared direction bit.
REQ-020 Breath direction SHALL flip to down when any level would exceed LVL_MAX and to up when any would go below LVL_MIN. The offending step SHALL be replaced by a step in the new direction. Levels out of lockstep converge at the bounds by saturation.
REQ-021 Entering BREATH SHALL clear the step counter and set direction up. Leaving BREATH SHALL retain current levels.
REQ-022 pwm_cnt SHALL count 0..LVL_MAX-1 every clk, then wrap to 0.
REQ-023 Each channel SHALL hold a shadow level, loaded from level[i] only in the cycle pwm_cnt wraps to 0, so periods are glitch-free.
REQ-024 pwm_out[i] SHALL be registered (pwm_cnt < shadow[i]), i.e. one-cycle latency. With level LVL_MAX, pwm_out[i] SHALL be constantly high.
REQ-025 Arithmetic SHALL be unsigned at LVL_W bits with no wrap-around past the bounds.

Reset
REQ-026 rst_n low SHALL asynchronously set: all levels and shadows = LVL_MIN, mode = UP, direction up, step counter = 0, pwm_cnt = 0, pwm_out = 0.
REQ-027 Reset mid-BREATH or mid-period SHALL take effect immediately. The first post-reset period starts at pwm_cnt = 0.
REQ-028 Keys pulsed while rst_n is low SHALL have no effect.

Verification (CH=3, LVL_MIN=1, LVL_MAX=25, STEP_CYC=4)
REQ-029 Reset, then 30 key_ch=3'b001 pulses in UP -> level[0]=25 (saturated), level[1]=level[2]=1; pwm_out[0] constantly high after the next wrap.
REQ-030 key_mode once, then 30 key_ch=3'b010 pulses -> mode=1, level[1] stays 1. key_ch=3'b011 -> no level change.
REQ-031 Level[2] 1->13 mid-period -> pwm_out[2] keeps 1 high cycle until the wrap, then 13 high / 12 low per 25-cycle period.
REQ-032 BREATH from all levels=1 -> +1 every 4 cycles to 25, then down to 1. Period 192 cycles; extremes never exceeded.
REQ-033 Simultaneous key_mode and key_ch=3'b001 in UP -> mode=1, level[0] unchanged.
REQ-034 rst_n low mid-BREATH at level 17 -> all levels=1, mode=0, pwm_out=0 within the same cycle.
